// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, state type and frame builder for the UART transmit path.
package uart_pkg;
    localparam int FRAME_BITS = 11;
    localparam int BITCNT_W = 4;
    typedef enum logic {IDLE, SEND} state_t;
    // Always 11 bits: unused parity/data slots become extra stop bits.
    function automatic logic [FRAME_BITS-1:0] uart_frame(input logic [7:0] data, input logic eight,
                                                         input logic pen, input logic ohel);
        logic [7:0] d;
        logic par, b8, b9;
        d = eight ? data : {1'b0, data[6:0]};
        par = ohel ^ (^d);
        b8 = eight ? data[7] : (pen ? par : 1'b1);
        b9 = (eight & pen) ? par : 1'b1;
        return {1'b1, b9, b8, data[6:0], 1'b0};
    endfunction
endpackage

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: one-entry holding register feeding an 11-bit frame shifter paced by btu.
module uart_tx_engine
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       eight,
    input  logic       pen,
    input  logic       ohel,
    input  logic       btu,
    output logic       doit,
    output logic       tx,
    output logic       txrdy
);
    localparam logic [BITCNT_W-1:0] LAST = BITCNT_W'(FRAME_BITS - 1);
    state_t state, state_n;
    logic [7:0] hold, hold_n;
    logic hold_v, hold_v_n;
    logic [FRAME_BITS-1:0] sr, sr_n, frm;
    logic [BITCNT_W-1:0] bitcnt, bitcnt_n;
    assign frm = uart_frame(hold, eight, pen, ohel);
    assign tx = sr[0];
    assign txrdy = ~hold_v;
    assign doit = (state == SEND);
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            hold <= '0;
            hold_v <= 1'b0;
            sr <= '1;
            bitcnt <= '0;
        end else begin
            state <= state_n;
            hold <= hold_n;
            hold_v <= hold_v_n;
            sr <= sr_n;
            bitcnt <= bitcnt_n;
        end
    end
    always_comb begin
        state_n = state;
        hold_n = hold;
        hold_v_n = hold_v;
        sr_n = sr;
        bitcnt_n = bitcnt;
        if (load && !hold_v) begin
            hold_n = din;
            hold_v_n = 1'b1;
        end
        // Load needs hold_v=0 and a transfer needs hold_v=1, so they never collide.
        if (state == IDLE) begin
            sr_n = '1;
            if (hold_v) begin
                sr_n = frm;
                hold_v_n = 1'b0;
                bitcnt_n = '0;
                state_n = SEND;
            end
        end else if (btu) begin
            if (bitcnt != LAST) begin
                sr_n = {1'b1, sr[FRAME_BITS-1:1]};
                bitcnt_n = bitcnt + 1'b1;
            end else if (hold_v) begin
                sr_n = frm;
                hold_v_n = 1'b0;
                bitcnt_n = '0;
            end else begin
                sr_n = '1;
                state_n = IDLE;
            end
        end
    end
endmodule
